pll_rst_seq: RTL and testbench



---
 rtl/pll_rst_pkg.sv | 14 +
 rtl/cdc_bit_sync.sv | 15 +
 rtl/pll_rst_seq.sv | 92 +++++++++
 tb/tb_pll_rst_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding and default constants for the PLL reset sequencer.
package pll_rst_pkg;
  typedef enum logic [2:0] {WAIT_LOCK, PLL_RST, STABLE, RELEASE, RUN} rst_seq_state_t;
  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_LOCK_STABLE_CYCLES = 1024;
  localparam int DEF_STEP_CYCLES        = 16;
  localparam int DEF_NUM_RST            = 4;
  localparam int DEF_LOCK_TIMEOUT       = 65536;
  localparam int DEF_PLL_RST_CYCLES     = 64;
  localparam int RELOCK_CNT_W           = 8;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/cdc_bit_sync.sv
// cdc_bit_sync: multi-flop single-bit synchroniser with synchronous active-low clear.
module cdc_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;
  always_ff @(posedge clk)
    if (!rst_n) ff <= '0;
    else ff <= {ff[STAGES-2:0], d};
  assign q = ff[STAGES-1];
endmodule

// File: rtl/pll_rst_seq.sv
// pll_rst_seq: qualifies PLL lock, releases domain resets in order, re-asserts on lock loss.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int STEP_CYCLES        = DEF_STEP_CYCLES,
  parameter int NUM_RST            = DEF_NUM_RST,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_lock,
  output logic                    pll_rst_req,
  output logic [NUM_RST-1:0]      rst_n_out,
  output logic                    seq_done,
  output logic [RELOCK_CNT_W-1:0] relock_cnt
);
  localparam int MAX_CYC = max2(max2(LOCK_STABLE_CYCLES, STEP_CYCLES), max2(LOCK_TIMEOUT, PLL_RST_CYCLES));
  localparam int CNT_W = max2(1, $clog2(MAX_CYC));
  localparam int IDX_W = NUM_RST > 1 ? $clog2(NUM_RST) : 1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_LAST    = CNT_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_RST - 1);
  rst_seq_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             lock_s;
  cdc_bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (pll_lock),
    .q    (lock_s)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= WAIT_LOCK;
      cnt         <= '0;
      idx         <= '0;
      rst_n_out   <= '0;
      pll_rst_req <= 1'b0;
      seq_done    <= 1'b0;
      relock_cnt  <= '0;
    end else begin
      case (state)
        WAIT_LOCK:
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_rst_req <= 1'b1;
          end else cnt <= cnt + 1'b1;
        PLL_RST:
          if (cnt == PULSE_LAST) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            pll_rst_req <= 1'b0;
          end else cnt <= cnt + 1'b1;
        STABLE:
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else cnt <= cnt + 1'b1;
        RELEASE, RUN:
          // any single low sample of lock_s drops every domain at once
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            rst_n_out <= '0;
            seq_done  <= 1'b0;
            if (relock_cnt != '1) relock_cnt <= relock_cnt + 1'b1;
          end else if (state == RUN) seq_done <= 1'b1;
          else if (cnt == STEP_LAST) begin
            rst_n_out[idx] <= 1'b1;
            cnt            <= '0;
            if (idx == IDX_LAST) state <= RUN;
            else idx <= idx + 1'b1;
          end else cnt <= cnt + 1'b1;
        default: state <= WAIT_LOCK;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: randomized and directed scenarios checked against a timeline reference model.
module tb_pll_rst_seq;
  localparam int SS = 2, LS = 8, ST = 4, NR = 4, TO = 32, PR = 5;
  typedef struct packed {
    logic          req;
    logic [NR-1:0] rn;
    logic          done;
    logic [7:0]    rc;
  } obs_t;
  logic clk = 1'b0, rst_n = 1'b0, pll_lock = 1'b0;
  logic pll_rst_req, seq_done;
  logic [NR-1:0] rst_n_out;
  logic [7:0] relock_cnt;
  obs_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int e = 0, t0 = 0, mode = 0, relock = 0;
  logic s1 = 1'b0, ls = 1'b0;

  pll_rst_seq #(
    .SYNC_STAGES(SS), .LOCK_STABLE_CYCLES(LS), .STEP_CYCLES(ST),
    .NUM_RST(NR), .LOCK_TIMEOUT(TO), .PLL_RST_CYCLES(PR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_rst_req(pll_rst_req),
    .rst_n_out(rst_n_out), .seq_done(seq_done), .relock_cnt(relock_cnt)
  );

  always #5 clk = ~clk;

  // mode: 0 waiting for lock, 1 PLL reset pulse, 2 lock seen (qualify/release/run by elapsed time)
  task automatic step(input logic r, input logic l);
    logic lsin;
    int d;
    obs_t x;
    e++;
    lsin = ls;
    if (!r) begin
      s1 = 0; ls = 0; mode = 0; t0 = e; relock = 0;
    end else begin
      ls = s1;
      s1 = l;
      if (mode == 0) begin
        if (lsin) begin mode = 2; t0 = e; end
        else if (e - t0 == TO) begin mode = 1; t0 = e; end
      end else if (mode == 1) begin
        if (e - t0 == PR) begin mode = 0; t0 = e; end
      end else if (!lsin) begin
        if (e - t0 >= LS + 1 && relock < 255) relock++;
        mode = 0; t0 = e;
      end
    end
    d = e - t0;
    x.req = (mode == 1);
    for (int i = 0; i < NR; i++) x.rn[i] = (mode == 2) && (d >= LS + ST * (i + 1));
    x.done = (mode == 2) && (d >= LS + ST * NR + 1);
    x.rc = 8'(relock);
    exp_q.push_back(x);
  endtask

  task automatic drive(input logic r, input logic l, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = r;
      pll_lock = l;
      step(r, l);
    end
  endtask

  initial begin : monitor
    obs_t x, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        a = {pll_rst_req, rst_n_out, seq_done, relock_cnt};
        n_checks++;
        if (a !== x) begin
          n_fail++;
          $display("FAIL outputs @%0t: got req=%b rst_n_out=%b done=%b relock=%0d, expected req=%b rst_n_out=%b done=%b relock=%0d",
                   $time, a.req, a.rn, a.done, a.rc, x.req, x.rn, x.done, x.rc);
        end
      end
    end
  end

  initial begin : stim
    drive(0, 0, 3);
    drive(1, 1, 40);
    drive(1, 0, 1);
    drive(1, 1, 40);
    drive(0, 0, 2);
    drive(1, 1, 6);
    drive(1, 0, 1);
    drive(1, 1, 40);
    drive(0, 0, 2);
    drive(1, 0, 120);
    drive(0, 0, 2);
    drive(1, 1, 20);
    drive(0, 1, 1);
    drive(1, 1, 35);
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 19) == 0) drive(0, 1'($urandom_range(0, 1)), 1);
      drive(1, 1'($urandom_range(0, 1)), $urandom_range(1, 45));
    end
    drive(0, 0, 2);
    for (int s = 0; s < 300; s++) begin
      drive(1, 1, 30);
      drive(1, 0, $urandom_range(1, 3));
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (relock_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL relock_saturation: got %0d, expected 255", relock_cnt);
    end
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
